// File: rtl/cc_buf_reg_drain.sv
// Read-side drain of the path buffer: 2-entry FWFT register buffer feeding encryption,
// with per-phase hand-off counting. Optional sticky error flag under CC_DRAIN_ERROR_CHECK_EN.
module cc_buf_reg_drain #(
  parameter int DWidth            = 512,
  parameter int ORAML             = 10,
  parameter int BktSize_DRBursts  = 6,
  localparam int PathSize_DRBursts = BktSize_DRBursts * (ORAML + 1),
  localparam int CtrWidth          = $clog2(PathSize_DRBursts)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ROAccess,
  input  logic                RWAccess,
  input  logic                DrainStart,
  input  logic                BufReg_InValid,
  input  logic [DWidth-1:0]   BufDOut,
  output logic [1:0]          BufReg_EmptyCount,
  output logic [DWidth-1:0]   ToEncData,
  output logic                ToEncDataValid,
  input  logic                ToEncDataReady,
  output logic [CtrWidth-1:0] DrainCount,
  output logic                DrainDone,
  output logic                DrainError,
  output logic                DrainActive
);

  // Handshake: a word moves to encryption on a cycle where ToEncDataValid and
  // ToEncDataReady are both high; Valid never depends on Ready.

  localparam logic [CtrWidth-1:0] PATH_LAST = CtrWidth'(PathSize_DRBursts - 1);
  localparam logic [CtrWidth-1:0] HDR_LAST  = CtrWidth'(ORAML);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  logic [DWidth-1:0]   head_q, head_d;
  logic [DWidth-1:0]   tail_q, tail_d;
  logic [1:0]          occ_q, occ_d;
  state_t              state_q;
  logic [CtrWidth-1:0] last_q;
  logic [CtrWidth-1:0] count_q;
  logic                done_q;

  logic push;
  logic pop;
  logic start_ok;

  assign push     = BufReg_InValid;
  assign pop      = (occ_q != 2'd0) && ToEncDataReady;
  assign start_ok = DrainStart && (RWAccess ^ ROAccess);

  // head_q is always the oldest word; tail_q only matters at occupancy 2.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = BufDOut;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b11: head_d = BufDOut;
          2'b10: begin
            tail_d = BufDOut;
            occ_d  = 2'd2;
          end
          2'b01: occ_d = 2'd0;
          default: occ_d = occ_q;
        endcase
      end
      default: begin
        // A push without a pop at occupancy 2 is dropped.
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
          if (push) begin
            tail_d = BufDOut;
            occ_d  = 2'd2;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      last_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            last_q  <= RWAccess ? PATH_LAST : HDR_LAST;
            count_q <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The final hand-off leaves the count at Target-1 rather than wrapping.
          if (pop) begin
            if (count_q == last_q) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BufReg_EmptyCount = 2'd2 - occ_q;
  assign ToEncData         = head_q;
  assign ToEncDataValid    = (occ_q != 2'd0);
  assign DrainCount        = count_q;
  assign DrainDone         = done_q;
  assign DrainActive       = (state_q == S_DRAIN);

`ifdef CC_DRAIN_ERROR_CHECK_EN
  logic err_q;
  logic err_ev;

  assign err_ev = (push && (occ_q == 2'd2) && !pop)
                || (push && (state_q == S_IDLE))
                || (DrainStart && ((state_q == S_DRAIN) || !(RWAccess ^ ROAccess)));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (err_ev) begin
      err_q <= 1'b1;
    end
  end

  assign DrainError = err_q;
`else
  assign DrainError = 1'b0;
`endif

endmodule

// File: tb/tb_cc_buf_reg_drain.sv
// Bench for cc_buf_reg_drain: random data against a queue/counter reference model,
// one task per scenario, inline comparisons.
module tb_cc_buf_reg_drain;

  localparam int DW   = 512;
  localparam int PATH = 66;
  localparam int HDR  = 11;
`ifdef CC_DRAIN_ERROR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          Clock;
  logic          Reset;
  logic          ROAccess;
  logic          RWAccess;
  logic          DrainStart;
  logic          BufReg_InValid;
  logic [DW-1:0] BufDOut;
  logic [1:0]    BufReg_EmptyCount;
  logic [DW-1:0] ToEncData;
  logic          ToEncDataValid;
  logic          ToEncDataReady;
  logic [6:0]    DrainCount;
  logic          DrainDone;
  logic          DrainError;
  logic          DrainActive;

  cc_buf_reg_drain dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .ROAccess          (ROAccess),
    .RWAccess          (RWAccess),
    .DrainStart        (DrainStart),
    .BufReg_InValid    (BufReg_InValid),
    .BufDOut           (BufDOut),
    .BufReg_EmptyCount (BufReg_EmptyCount),
    .ToEncData         (ToEncData),
    .ToEncDataValid    (ToEncDataValid),
    .ToEncDataReady    (ToEncDataReady),
    .DrainCount        (DrainCount),
    .DrainDone         (DrainDone),
    .DrainError        (DrainError),
    .DrainActive       (DrainActive)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: buffer contents, phase bookkeeping, sticky error.
  logic [DW-1:0] exp_q[$];
  bit m_drain;
  int m_target;
  int m_count;
  bit m_done;
  bit m_err;

  int vectors;
  int miscompares;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Advance one clock, update the model from the inputs seen at that edge, settle.
  task automatic step();
    bit pop, push, acc, ev;
    @(posedge Clock);
    if (Reset) begin
      exp_q.delete();
      m_drain = 0; m_target = 0; m_count = 0; m_done = 0; m_err = 0;
    end else begin
      pop  = (exp_q.size() != 0) && ToEncDataReady;
      push = BufReg_InValid;
      acc  = DrainStart && !m_drain && (ROAccess != RWAccess);
      ev   = (push && exp_q.size() == 2 && !pop) || (push && !m_drain)
           || (DrainStart && (m_drain || ROAccess == RWAccess));
      if (pop) void'(exp_q.pop_front());
      if (push && exp_q.size() < 2) exp_q.push_back(BufDOut);
      m_done = 0;
      if (m_drain && pop) begin
        if (m_count == m_target - 1) begin
          m_done = 1;
          m_drain = 0;
        end else begin
          m_count++;
        end
      end else if (acc) begin
        m_drain  = 1;
        m_target = RWAccess ? PATH : HDR;
        m_count  = 0;
      end
      m_err = m_err | (ERR_EN & ev);
    end
    #1;
  endtask

  task automatic idle_inputs();
    Reset = 0; DrainStart = 0; RWAccess = 0; ROAccess = 0;
    BufReg_InValid = 0; BufDOut = '0; ToEncDataReady = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1;
    step();
    Reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1; DrainStart = 1; RWAccess = 1; BufReg_InValid = 1;
    BufDOut = rand_word(); ToEncDataReady = 1;
    step();
    step();
    vectors++;
    if (BufReg_EmptyCount !== 2'd2) begin miscompares++; $display("FAIL reset empty: got %0d want 2", BufReg_EmptyCount); end
    if (ToEncDataValid !== 1'b0) begin miscompares++; $display("FAIL reset valid: got %0b want 0", ToEncDataValid); end
    if (ToEncData !== '0) begin miscompares++; $display("FAIL reset data: got %h want 0", ToEncData); end
    if (DrainCount !== 7'd0) begin miscompares++; $display("FAIL reset count: got %0d want 0", DrainCount); end
    if (DrainDone !== 1'b0) begin miscompares++; $display("FAIL reset done: got %0b want 0", DrainDone); end
    if (DrainError !== 1'b0) begin miscompares++; $display("FAIL reset error: got %0b want 0", DrainError); end
    if (DrainActive !== 1'b0) begin miscompares++; $display("FAIL reset active: got %0b want 0", DrainActive); end
    idle_inputs();
  endtask

  task automatic test_rw_drain();
    logic [DW-1:0] w;
    int dones, done_c;
    dones = 0; done_c = -1;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      DrainStart = (c == 0); RWAccess = (c == 0); ROAccess = 0;
      w = rand_word();
      BufReg_InValid = (c >= 1 && c <= 66); BufDOut = w; ToEncDataReady = 1;
      step();
      vectors++;
      if (ToEncDataValid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL rw valid c=%0d: got %0b want %0b", c, ToEncDataValid, exp_q.size() != 0); end
      if (exp_q.size() != 0 && ToEncData !== exp_q[0]) begin miscompares++; $display("FAIL rw data c=%0d: got %h want %h", c, ToEncData, exp_q[0]); end
      if (BufReg_EmptyCount !== 2'(2 - exp_q.size())) begin miscompares++; $display("FAIL rw empty c=%0d: got %0d want %0d", c, BufReg_EmptyCount, 2 - exp_q.size()); end
      if (DrainCount !== 7'(m_count)) begin miscompares++; $display("FAIL rw count c=%0d: got %0d want %0d", c, DrainCount, m_count); end
      if (DrainDone !== m_done) begin miscompares++; $display("FAIL rw done c=%0d: got %0b want %0b", c, DrainDone, m_done); end
      if (DrainError !== m_err) begin miscompares++; $display("FAIL rw error c=%0d: got %0b want %0b", c, DrainError, m_err); end
      if (DrainActive !== m_drain) begin miscompares++; $display("FAIL rw active c=%0d: got %0b want %0b", c, DrainActive, m_drain); end
      if (c >= 1 && c <= 66 && (ToEncDataValid !== 1'b1 || ToEncData !== w)) begin
        miscompares++; $display("FAIL rw latency c=%0d: got %h want %h", c, ToEncData, w);
      end
      if (DrainDone === 1'b1) begin dones++; done_c = c; end
    end
    vectors++;
    if (dones != 1 || done_c != 67) begin miscompares++; $display("FAIL rw done_pulse: got %0d pulses at %0d want 1 at 67", dones, done_c); end
    if (DrainCount !== 7'd65) begin miscompares++; $display("FAIL rw final_count: got %0d want 65", DrainCount); end
    if (BufReg_EmptyCount !== 2'd2) begin miscompares++; $display("FAIL rw final_empty: got %0d want 2", BufReg_EmptyCount); end
    if (DrainActive !== 1'b0) begin miscompares++; $display("FAIL rw final_idle: got %0b want 0", DrainActive); end
    idle_inputs();
  endtask

  task automatic test_ro_backpressure();
    int npush, dones;
    npush = 0; dones = 0;
    do_reset();
    for (int c = 0; c < 120; c++) begin
      DrainStart = (c == 0); ROAccess = (c == 0); RWAccess = 0;
      ToEncDataReady = (c % 2 == 1);
      BufReg_InValid = (c > 0) && (npush < HDR) && (exp_q.size() < 2 || ToEncDataReady)
                     && ($urandom_range(0, 3) != 0);
      if (BufReg_InValid) npush++;
      BufDOut = rand_word();
      step();
      vectors++;
      if (ToEncDataValid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL ro valid c=%0d: got %0b want %0b", c, ToEncDataValid, exp_q.size() != 0); end
      if (exp_q.size() != 0 && ToEncData !== exp_q[0]) begin miscompares++; $display("FAIL ro data c=%0d: got %h want %h", c, ToEncData, exp_q[0]); end
      if (BufReg_EmptyCount !== 2'(2 - exp_q.size())) begin miscompares++; $display("FAIL ro empty c=%0d: got %0d want %0d", c, BufReg_EmptyCount, 2 - exp_q.size()); end
      if (DrainCount !== 7'(m_count)) begin miscompares++; $display("FAIL ro count c=%0d: got %0d want %0d", c, DrainCount, m_count); end
      if (DrainDone !== m_done) begin miscompares++; $display("FAIL ro done c=%0d: got %0b want %0b", c, DrainDone, m_done); end
      if (DrainError !== m_err) begin miscompares++; $display("FAIL ro error c=%0d: got %0b want %0b", c, DrainError, m_err); end
      if (DrainActive !== m_drain) begin miscompares++; $display("FAIL ro active c=%0d: got %0b want %0b", c, DrainActive, m_drain); end
      if (BufReg_EmptyCount > 2'd2) begin miscompares++; $display("FAIL ro underflow c=%0d: got %0d want <=2", c, BufReg_EmptyCount); end
      if (DrainDone === 1'b1) dones++;
    end
    vectors++;
    if (npush != HDR) begin miscompares++; $display("FAIL ro pushes: got %0d want %0d", npush, HDR); end
    if (dones != 1) begin miscompares++; $display("FAIL ro done_pulse: got %0d want 1", dones); end
    if (DrainCount !== 7'd10) begin miscompares++; $display("FAIL ro final_count: got %0d want 10", DrainCount); end
    if (DrainActive !== 1'b0) begin miscompares++; $display("FAIL ro final_idle: got %0b want 0", DrainActive); end
    idle_inputs();
  endtask

  task automatic test_full_simul();
    logic [DW-1:0] w[7];
    bit push_v[7] = '{0, 1, 1, 1, 0, 0, 0};
    bit rdy_v[7]  = '{0, 0, 0, 1, 1, 1, 1};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      w[c] = rand_word();
      DrainStart = (c == 0); ROAccess = (c == 0); RWAccess = 0;
      BufReg_InValid = push_v[c]; BufDOut = w[c]; ToEncDataReady = rdy_v[c];
      step();
      vectors++;
      if (ToEncDataValid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL full valid c=%0d: got %0b want %0b", c, ToEncDataValid, exp_q.size() != 0); end
      if (exp_q.size() != 0 && ToEncData !== exp_q[0]) begin miscompares++; $display("FAIL full data c=%0d: got %h want %h", c, ToEncData, exp_q[0]); end
      if (BufReg_EmptyCount !== 2'(2 - exp_q.size())) begin miscompares++; $display("FAIL full empty c=%0d: got %0d want %0d", c, BufReg_EmptyCount, 2 - exp_q.size()); end
      if (DrainCount !== 7'(m_count)) begin miscompares++; $display("FAIL full count c=%0d: got %0d want %0d", c, DrainCount, m_count); end
      if (DrainDone !== m_done) begin miscompares++; $display("FAIL full done c=%0d: got %0b want %0b", c, DrainDone, m_done); end
      if (DrainError !== 1'b0) begin miscompares++; $display("FAIL full error c=%0d: got %0b want 0", c, DrainError); end
      if (c == 2 && BufReg_EmptyCount !== 2'd0) begin miscompares++; $display("FAIL full filled: got %0d want 0", BufReg_EmptyCount); end
      if (c == 3 && (BufReg_EmptyCount !== 2'd0 || ToEncData !== w[2])) begin miscompares++; $display("FAIL full simul: got empty %0d head %h want 0 %h", BufReg_EmptyCount, ToEncData, w[2]); end
      if (c == 4 && ToEncData !== w[3]) begin miscompares++; $display("FAIL full order: got %h want %h", ToEncData, w[3]); end
      if (c == 5 && BufReg_EmptyCount !== 2'd2) begin miscompares++; $display("FAIL full drained: got %0d want 2", BufReg_EmptyCount); end
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    logic [DW-1:0] w[8];
    bit push_v[8] = '{0, 1, 1, 1, 0, 0, 0, 0};
    bit rdy_v[8]  = '{0, 0, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      w[c] = rand_word();
      DrainStart = (c == 0); ROAccess = (c == 0); RWAccess = 0;
      BufReg_InValid = push_v[c]; BufDOut = w[c]; ToEncDataReady = rdy_v[c];
      step();
      vectors++;
      if (ToEncDataValid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL ovf valid c=%0d: got %0b want %0b", c, ToEncDataValid, exp_q.size() != 0); end
      if (exp_q.size() != 0 && ToEncData !== exp_q[0]) begin miscompares++; $display("FAIL ovf data c=%0d: got %h want %h", c, ToEncData, exp_q[0]); end
      if (BufReg_EmptyCount !== 2'(2 - exp_q.size())) begin miscompares++; $display("FAIL ovf empty c=%0d: got %0d want %0d", c, BufReg_EmptyCount, 2 - exp_q.size()); end
      if (DrainCount !== 7'(m_count)) begin miscompares++; $display("FAIL ovf count c=%0d: got %0d want %0d", c, DrainCount, m_count); end
      if (DrainError !== m_err) begin miscompares++; $display("FAIL ovf error c=%0d: got %0b want %0b", c, DrainError, m_err); end
      if (c == 2 && DrainError !== 1'b0) begin miscompares++; $display("FAIL ovf early_error: got %0b want 0", DrainError); end
      if (c == 3 && (DrainError !== ERR_EN || BufReg_EmptyCount !== 2'd0)) begin miscompares++; $display("FAIL ovf event: got err %0b empty %0d want %0b 0", DrainError, BufReg_EmptyCount, ERR_EN); end
      if (c == 5 && ToEncData !== w[2]) begin miscompares++; $display("FAIL ovf order: got %h want %h", ToEncData, w[2]); end
      if (c == 6 && BufReg_EmptyCount !== 2'd2) begin miscompares++; $display("FAIL ovf dropped: got %0d want 2", BufReg_EmptyCount); end
    end
    idle_inputs();
  endtask

  task automatic test_invalid_start();
    int dones, done_c;
    dones = 0; done_c = -1;
    do_reset();
    DrainStart = 1; ROAccess = 1; RWAccess = 1;
    step();
    vectors++;
    if (DrainActive !== 1'b0) begin miscompares++; $display("FAIL inv both_active: got %0b want 0", DrainActive); end
    if (DrainError !== ERR_EN) begin miscompares++; $display("FAIL inv both_error: got %0b want %0b", DrainError, ERR_EN); end
    do_reset();
    DrainStart = 1;
    step();
    vectors++;
    if (DrainActive !== 1'b0 || DrainError !== ERR_EN) begin miscompares++; $display("FAIL inv neither: got act %0b err %0b want 0 %0b", DrainActive, DrainError, ERR_EN); end
    do_reset();
    for (int c = 0; c < 72; c++) begin
      DrainStart = (c <= 1); RWAccess = (c == 0); ROAccess = (c == 1);
      BufReg_InValid = (c >= 2 && c <= 67); BufDOut = rand_word();
      ToEncDataReady = ($urandom_range(0, 3) != 0) || (c > 67);
      if (BufReg_InValid && exp_q.size() == 2 && !ToEncDataReady) ToEncDataReady = 1;
      step();
      vectors++;
      if (ToEncDataValid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL inv valid c=%0d: got %0b want %0b", c, ToEncDataValid, exp_q.size() != 0); end
      if (exp_q.size() != 0 && ToEncData !== exp_q[0]) begin miscompares++; $display("FAIL inv data c=%0d: got %h want %h", c, ToEncData, exp_q[0]); end
      if (DrainCount !== 7'(m_count)) begin miscompares++; $display("FAIL inv count c=%0d: got %0d want %0d", c, DrainCount, m_count); end
      if (DrainDone !== m_done) begin miscompares++; $display("FAIL inv done c=%0d: got %0b want %0b", c, DrainDone, m_done); end
      if (DrainError !== m_err) begin miscompares++; $display("FAIL inv error c=%0d: got %0b want %0b", c, DrainError, m_err); end
      if (DrainActive !== m_drain) begin miscompares++; $display("FAIL inv active c=%0d: got %0b want %0b", c, DrainActive, m_drain); end
      if (c == 1 && (DrainActive !== 1'b1 || DrainError !== ERR_EN)) begin miscompares++; $display("FAIL inv in_drain: got act %0b err %0b want 1 %0b", DrainActive, DrainError, ERR_EN); end
      if (DrainDone === 1'b1) begin dones++; done_c = c; end
    end
    vectors++;
    if (dones != 1 || DrainCount !== 7'd65) begin miscompares++; $display("FAIL inv target_kept: got %0d pulses count %0d want 1 65", dones, DrainCount); end
    idle_inputs();
  endtask

  task automatic test_push_idle();
    int dones;
    dones = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      DrainStart = (c == 1); ROAccess = (c == 1); RWAccess = 0;
      BufReg_InValid = (c == 0) || (c >= 2 && c <= 11) || (c == 13);
      BufDOut = rand_word(); ToEncDataReady = (c >= 2);
      step();
      vectors++;
      if (ToEncDataValid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL idle valid c=%0d: got %0b want %0b", c, ToEncDataValid, exp_q.size() != 0); end
      if (exp_q.size() != 0 && ToEncData !== exp_q[0]) begin miscompares++; $display("FAIL idle data c=%0d: got %h want %h", c, ToEncData, exp_q[0]); end
      if (DrainCount !== 7'(m_count)) begin miscompares++; $display("FAIL idle count c=%0d: got %0d want %0d", c, DrainCount, m_count); end
      if (DrainDone !== m_done) begin miscompares++; $display("FAIL idle done c=%0d: got %0b want %0b", c, DrainDone, m_done); end
      if (DrainError !== m_err) begin miscompares++; $display("FAIL idle error c=%0d: got %0b want %0b", c, DrainError, m_err); end
      if (c == 0 && DrainError !== ERR_EN) begin miscompares++; $display("FAIL idle event: got %0b want %0b", DrainError, ERR_EN); end
      if (DrainDone === 1'b1) dones++;
    end
    vectors++;
    if (dones != 1 || DrainCount !== 7'd10) begin miscompares++; $display("FAIL idle carried: got %0d pulses count %0d want 1 10", dones, DrainCount); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 39; c++) begin
      Reset = (c == 34);
      DrainStart = (c == 0); RWAccess = (c == 0); ROAccess = 0;
      BufReg_InValid = (c >= 1 && c <= 30) || c == 32 || c == 33;
      BufDOut = rand_word(); ToEncDataReady = (c <= 31);
      step();
      vectors++;
      if (ToEncDataValid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL rst valid c=%0d: got %0b want %0b", c, ToEncDataValid, exp_q.size() != 0); end
      if (DrainCount !== 7'(m_count)) begin miscompares++; $display("FAIL rst count c=%0d: got %0d want %0d", c, DrainCount, m_count); end
      if (DrainDone !== m_done) begin miscompares++; $display("FAIL rst done c=%0d: got %0b want %0b", c, DrainDone, m_done); end
      if (DrainError !== m_err) begin miscompares++; $display("FAIL rst error c=%0d: got %0b want %0b", c, DrainError, m_err); end
      if (c == 31 && DrainCount !== 7'd30) begin miscompares++; $display("FAIL rst pre_count: got %0d want 30", DrainCount); end
      if (c == 33 && BufReg_EmptyCount !== 2'd0) begin miscompares++; $display("FAIL rst pre_full: got %0d want 0", BufReg_EmptyCount); end
      if (c == 34 && (BufReg_EmptyCount !== 2'd2 || ToEncDataValid !== 1'b0 || DrainCount !== 7'd0 || DrainDone !== 1'b0 || DrainActive !== 1'b0)) begin
        miscompares++; $display("FAIL rst post: got empty %0d valid %0b count %0d done %0b active %0b want 2 0 0 0 0", BufReg_EmptyCount, ToEncDataValid, DrainCount, DrainDone, DrainActive);
      end
      if (c > 34 && DrainDone !== 1'b0) begin miscompares++; $display("FAIL rst stray_done c=%0d: got 1 want 0", c); end
    end
    idle_inputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_drain = 0; m_target = 0; m_count = 0; m_done = 0; m_err = 0;
    idle_inputs();
    test_reset();
    test_rw_drain();
    test_ro_backpressure();
    test_full_simul();
    test_overflow();
    test_invalid_start();
    test_push_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
